// File: rtl/trig_arbiter.sv
// Purpose: round-robin arbiter sharing one sin/cos lookup table among NUM_REQ motion requesters.
// Latency: req sampled at edge N -> grant after N -> response (rsp_valid) after N+1; one lookup per clock.
// Backpressure: none; a requester holds req/angle until it sees grant, the last grantee is masked for one cycle.
//
// Ports: frame_clk/Reset (async, active-high); req[NUM_REQ] level requests; angle_in[6*NUM_REQ]
// heading indices (0..MAX_ANGLE, 8 deg/step); grant one-hot; rsp_valid/rsp_id/sin_out/cos_out
// sign-magnitude response (bit7 = negative); bad_angle sticky out-of-range flag; busy activity flag.
// Optional macro TRIG_ARB_RESULT_HOLD_EN adds per-requester result slots sin_hold/cos_hold.
module trig_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ID_W      = 3,
    parameter int MAX_ANGLE = 44
) (
    input  logic                   frame_clk,
    input  logic                   Reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [6*NUM_REQ-1:0]   angle_in,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic [7:0]             sin_out,
    output logic [7:0]             cos_out,
    output logic                   bad_angle,
    output logic                   busy
`ifdef TRIG_ARB_RESULT_HOLD_EN
    ,
    output logic [8*NUM_REQ-1:0]   sin_hold,
    output logic [8*NUM_REQ-1:0]   cos_hold
`endif
);

    // ------------------------------------------------------------------
    // Stage 0: arbitration
    // ------------------------------------------------------------------
    logic [ID_W-1:0]    rr_ptr;
    logic [NUM_REQ-1:0] eligible;
    logic               win_found;
    logic [ID_W-1:0]    win_id;
    logic [NUM_REQ-1:0] win_onehot;
    logic [5:0]         win_angle;
    logic [ID_W-1:0]    next_ptr;
    logic [5:0]         angle_q;
    logic [ID_W-1:0]    id_q;

    always_comb begin
        // Last cycle's grantee is masked so it cannot win twice in a row.
        eligible   = req & ~grant;
        win_found  = 1'b0;
        win_id     = '0;
        win_onehot = '0;
        win_angle  = '0;
        // Offset i from rr_ptr lands on requester j either directly or after wrapping.
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!win_found && eligible[j] &&
                    ((int'(rr_ptr) + i == j) || (int'(rr_ptr) + i == j + NUM_REQ))) begin
                    win_found     = 1'b1;
                    win_id        = ID_W'(j);
                    win_onehot[j] = 1'b1;
                    win_angle     = angle_in[6*j +: 6];
                end
            end
        end
        next_ptr = (int'(win_id) == NUM_REQ - 1) ? '0 : win_id + ID_W'(1);
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            grant   <= '0;
            rr_ptr  <= '0;
            angle_q <= '0;
            id_q    <= '0;
        end else if (win_found) begin
            grant   <= win_onehot;
            rr_ptr  <= next_ptr;
            angle_q <= win_angle;
            id_q    <= win_id;
        end else begin
            grant   <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: table lookup
    // ------------------------------------------------------------------
    // Magnitudes round(127*sin x) and round(127*cos x) for x = 4k degrees, k = 0..22.
    // Every multiple of 8 degrees folds onto one of these first-quadrant angles.
    function automatic logic [13:0] mag_lut(input logic [4:0] k);
        case (k)
            5'd0:    mag_lut = {7'd0,   7'd127};
            5'd1:    mag_lut = {7'd9,   7'd127};
            5'd2:    mag_lut = {7'd18,  7'd126};
            5'd3:    mag_lut = {7'd26,  7'd124};
            5'd4:    mag_lut = {7'd35,  7'd122};
            5'd5:    mag_lut = {7'd43,  7'd119};
            5'd6:    mag_lut = {7'd52,  7'd116};
            5'd7:    mag_lut = {7'd60,  7'd112};
            5'd8:    mag_lut = {7'd67,  7'd108};
            5'd9:    mag_lut = {7'd75,  7'd103};
            5'd10:   mag_lut = {7'd82,  7'd97};
            5'd11:   mag_lut = {7'd88,  7'd91};
            5'd12:   mag_lut = {7'd94,  7'd85};
            5'd13:   mag_lut = {7'd100, 7'd78};
            5'd14:   mag_lut = {7'd105, 7'd71};
            5'd15:   mag_lut = {7'd110, 7'd64};
            5'd16:   mag_lut = {7'd114, 7'd56};
            5'd17:   mag_lut = {7'd118, 7'd48};
            5'd18:   mag_lut = {7'd121, 7'd39};
            5'd19:   mag_lut = {7'd123, 7'd31};
            5'd20:   mag_lut = {7'd125, 7'd22};
            5'd21:   mag_lut = {7'd126, 7'd13};
            5'd22:   mag_lut = {7'd127, 7'd4};
            default: mag_lut = {7'd0,   7'd127};
        endcase
    endfunction

    logic        angle_bad;
    logic [5:0]  lut_idx;
    logic [6:0]  a2;
    logic [4:0]  fold_k;
    logic        sin_neg;
    logic        cos_neg;
    logic [13:0] mags;
    logic [7:0]  sin_val;
    logic [7:0]  cos_val;

    always_comb begin
        angle_bad = (angle_q > 6'(MAX_ANGLE));
        lut_idx   = angle_bad ? 6'd0 : angle_q;
        a2        = {lut_idx, 1'b0};
        fold_k    = '0;
        sin_neg   = 1'b0;
        cos_neg   = 1'b0;
        // Quadrant folding of theta = 8a degrees; k is the folded angle in 4-degree units.
        if (lut_idx <= 6'd11) begin
            fold_k = a2[4:0];                    // 0..88: theta itself
        end else if (lut_idx <= 6'd22) begin
            fold_k  = 5'(7'd45 - a2);            // 96..176: 180 - theta
            cos_neg = 1'b1;
        end else if (lut_idx <= 6'd33) begin
            fold_k  = 5'(a2 - 7'd45);            // 184..264: theta - 180
            sin_neg = 1'b1;
            cos_neg = 1'b1;
        end else if (lut_idx <= 6'd44) begin
            fold_k  = 5'(7'd90 - a2);            // 272..352: 360 - theta
            sin_neg = 1'b1;
        end
        mags = mag_lut(fold_k);
        // A zero magnitude never carries a sign.
        sin_val = {sin_neg && (mags[13:7] != 7'd0), mags[13:7]};
        cos_val = {cos_neg && (mags[6:0]  != 7'd0), mags[6:0]};
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            sin_out   <= 8'h00;
            cos_out   <= 8'h7F;
            bad_angle <= 1'b0;
        end else begin
            rsp_valid <= |grant;
            if (|grant) begin
                rsp_id  <= id_q;
                sin_out <= sin_val;
                cos_out <= cos_val;
                if (angle_bad) begin
                    bad_angle <= 1'b1;
                end
            end
        end
    end

    assign busy = (|grant) | rsp_valid;

`ifdef TRIG_ARB_RESULT_HOLD_EN
    // Per-requester copy of the most recent response, so requesters need no capture logic.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                sin_hold[8*j +: 8] <= 8'h00;
                cos_hold[8*j +: 8] <= 8'h7F;
            end
        end else if (rsp_valid) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (rsp_id == ID_W'(j)) begin
                    sin_hold[8*j +: 8] <= sin_out;
                    cos_hold[8*j +: 8] <= cos_out;
                end
            end
        end
    end
`endif

endmodule

// File: doc/trig_arbiter.md
Name: trig_arbiter

Overview:
- Shares a single sin/cos lookup table among several motion requesters: both tank movers and the projectile updaters.
- Each requester presents a 6-bit heading index (0..44, 8 degrees per step). The block grants requesters round-robin, one lookup per clock, and returns sign-magnitude sin/cos tagged with the requester ID.
- Sits between the tank/bullet movement blocks and the trig table. It replaces per-tank table copies.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 3, width of rsp_id. Must satisfy 2^ID_W >= NUM_REQ.
- MAX_ANGLE, 44, largest legal heading index.

Ports:
- frame_clk  input  1  clock.
- Reset  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-requester lookup request, level.
- angle_in  input  6*NUM_REQ  heading index; requester i uses bits [6i+5:6i].
- grant  output  NUM_REQ  one-hot, registered; requester i accepted.
- rsp_valid  output  1  sin_out/cos_out/rsp_id valid this cycle.
- rsp_id  output  ID_W  requester index of the current response.
- sin_out  output  8  bit7 = sign (1 = negative), [6:0] = magnitude.
- cos_out  output  8  same format.
- bad_angle  output  1  sticky; a granted angle exceeded MAX_ANGLE.
- busy  output  1  grant or rsp_valid currently high.

Behaviour:
Reset values:
- grant=0, rsp_valid=0, rsp_id=0, sin_out=0x00, cos_out=0x7F, bad_angle=0.
- Round-robin pointer rr_ptr=0.

Stage 0, arbitration (registered):
- Each edge, the eligible set is req AND NOT grant. The requester granted last cycle is masked, so one requester is granted at most every other cycle.
- Scan starts at rr_ptr and goes upward with wrap; the first eligible requester wins.
- The winner's grant bit is set for one cycle, and its angle is latched into angle_q along with id_q.
- rr_ptr becomes (winner+1) mod NUM_REQ. With no eligible requester: grant=0 and rr_ptr unchanged.

Stage 1, table lookup (registered):
- On the edge after a grant: rsp_valid=1, rsp_id=id_q, and sin_out/cos_out come from the table at angle_q.
- Total latency: req sampled at edge N, grant high after N, response high after N+1.
- rsp_valid lasts exactly one cycle per grant. Back-to-back grants give back-to-back responses.
- Outside responses, sin_out/cos_out/rsp_id hold their last values.

Requester rule:
- Hold req and angle_in stable until grant is seen, then deassert req by the next edge.
- A req still high after that is treated as a new request.

Table contents:
- Entry a: magnitude = round(127*|f(8a deg)|), f = sin or cos.
- Sign bit = 1 only when the value is negative and the magnitude is nonzero. Zero is always 0x00.
- Examples: a=0 gives sin 0x00, cos 0x7F. a=11 gives sin 0x7F, cos 0x04.

Out-of-range angle:
- If angle_q > MAX_ANGLE, the table uses index 0 and bad_angle is set.
- bad_angle is cleared only by Reset.

Other rules:
- Simultaneous requests from all requesters are served over NUM_REQ consecutive cycles, in rr_ptr order.
- A request arriving while its own grant is high waits at least one cycle.
- Reset mid-operation clears the in-flight grant and response immediately; no response is produced for them.
- busy = |grant OR rsp_valid.

Optional Feature:
- Macro TRIG_ARB_RESULT_HOLD_EN.
- When defined, adds outputs sin_hold and cos_hold, each 8*NUM_REQ wide. Slot rsp_id updates on rsp_valid and the updated value is visible the cycle after rsp_valid.
- Hold slots reset to sin 0x00 / cos 0x7F, so requesters need no capture logic.
- When undefined, these ports and registers are absent. All other behaviour is identical.

Test Plan:
1. Reset, then req=0001 with angle0=0 -> grant=0001 one cycle later; the next cycle gives rsp_valid=1, rsp_id=0, sin 0x00, cos 0x7F.
2. req=1111 held with angles 0/11/23/34 and each req dropped after its grant -> grants 0001,0010,0100,1000 on consecutive cycles. Responses (sin,cos): (0x00,0x7F), (0x7F,0x04), (0x89,0xFF), (0xFF,0x04).
3. req0 held high continuously with angle 11 and no other requests -> grant0 on alternating cycles only; rsp_valid alternates; rr_ptr returns to 1 after each grant.
4. Requester 2 sends angle 45 -> response has sin 0x00, cos 0x7F and bad_angle=1. bad_angle stays high through later legal lookups until Reset.
5. Reset pulsed on the cycle grant=0100 -> the next cycles show grant=0, rsp_valid=0, rsp_id=0, cos_out=0x7F, rr_ptr=0. The next request from requester 3 is granted normally.
6. With TRIG_ARB_RESULT_HOLD_EN defined, requester 1 looks up angle 23 -> sin_hold[15:8]=0x89 and cos_hold[15:8]=0xFF the cycle after rsp_valid; other slots keep their reset values.
